// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame transmitter and its CRC helper.
package can_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID_A,
    ST_SRR,
    ST_IDE,
    ST_ID_B,
    ST_RTR,
    ST_R1,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } tx_state_e;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int ID_A_LEN  = 11;
  localparam int ID_B_LEN  = 18;
  localparam int DLC_LEN   = 4;
  localparam int CRC_LEN   = 15;
  localparam int EOF_LEN   = 7;
  localparam int IFS_LEN   = 3;
  localparam int STUFF_RUN = 5;

  // The enum order above is relied on by these range helpers.
  function automatic logic is_stuffed(input tx_state_e s);
    return (s >= ST_SOF) && (s <= ST_CRC);
  endfunction

  function automatic logic in_crc_span(input tx_state_e s);
    return (s >= ST_SOF) && (s <= ST_DATA);
  endfunction

  function automatic logic is_arb_field(input tx_state_e s);
    return (s >= ST_ID_A) && (s <= ST_RTR);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register: clear, shift-enable and one data bit per shift.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [14:0] crc_o
);

  logic [14:0] crc_q;
  logic [14:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[13:0], 1'b0} ^ ((bit_i ^ crc_q[14]) ? CRC15_POLY : 15'h0000);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A/2.0B frame transmitter: serialises one frame with stuffing and CRC-15,
// checking the bus at each sample point for arbitration loss, bit error and missing ACK.
module can_frame_tx
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        BIT_EN,
  input  logic        SP,
  input  logic        RX,
  input  logic        START,
  input  logic        IDE,
  input  logic        RTR,
  input  logic [28:0] IDF,
  input  logic [3:0]  DLC,
  input  logic [63:0] DATA,
  output logic        TX,
  output logic        BUSY,
  output logic        DONE,
  output logic        ARB_LOST,
  output logic        BIT_ERR,
  output logic        ACK_ERR,
  output logic        STF_BIT
);

  // Handshake: START is a one-clk request, taken only while BUSY=0; fields are
  // captured in that cycle and the frame owns the bus until BUSY falls.

  tx_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  run_q, run_d;
  logic        tx_q, tx_d;
  logic        stf_q, stf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        arb_q, arb_d;
  logic        bit_err_q, bit_err_d;
  logic        ack_err_q, ack_err_d;
  logic        ide_q, ide_d;
  logic        rtr_q, rtr_d;
  logic [28:0] idf_q, idf_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [63:0] data_q, data_d;
  logic        no_data_q, no_data_d;
  logic [5:0]  dlast_q, dlast_d;

  logic        crc_clr;
  logic        crc_en;
  logic        crc_bit;
  logic [14:0] crc_val;

  logic [10:0] id_a;
  logic [3:0]  nb_clamped;
  tx_state_e   adv_state;
  logic [5:0]  adv_cnt;
  logic        adv_bit;
  logic        finish;

  can_crc15 u_crc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .bit_i  (crc_bit),
    .crc_o  (crc_val)
  );

  assign id_a       = ide_q ? idf_q[28:18] : idf_q[10:0];
  assign nb_clamped = (DLC > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : DLC;

  // Next real (non-stuff) bit after the one currently on TX: its field, index and level.
  always_comb begin
    adv_state = state_q;
    adv_cnt   = cnt_q - 6'd1;
    adv_bit   = 1'b1;
    if (cnt_q == 6'd0) begin
      adv_cnt = 6'd0;
      case (state_q)
        ST_SOF:      begin adv_state = ST_ID_A; adv_cnt = 6'(ID_A_LEN - 1); end
        ST_ID_A:     adv_state = ide_q ? ST_SRR : ST_RTR;
        ST_SRR:      adv_state = ST_IDE;
        ST_IDE: begin
          if (ide_q) begin
            adv_state = ST_ID_B;
            adv_cnt   = 6'(ID_B_LEN - 1);
          end else begin
            adv_state = ST_R0;
          end
        end
        ST_ID_B:     adv_state = ST_RTR;
        ST_RTR:      adv_state = ide_q ? ST_R1 : ST_IDE;
        ST_R1:       adv_state = ST_R0;
        ST_R0:       begin adv_state = ST_DLC; adv_cnt = 6'(DLC_LEN - 1); end
        ST_DLC: begin
          if (no_data_q) begin
            adv_state = ST_CRC;
            adv_cnt   = 6'(CRC_LEN - 1);
          end else begin
            adv_state = ST_DATA;
            adv_cnt   = dlast_q;
          end
        end
        ST_DATA:     begin adv_state = ST_CRC; adv_cnt = 6'(CRC_LEN - 1); end
        ST_CRC:      adv_state = ST_CRC_DEL;
        ST_CRC_DEL:  adv_state = ST_ACK_SLOT;
        ST_ACK_SLOT: adv_state = ST_ACK_DEL;
        ST_ACK_DEL:  begin adv_state = ST_EOF; adv_cnt = 6'(EOF_LEN - 1); end
        ST_EOF:      begin adv_state = ST_IFS; adv_cnt = 6'(IFS_LEN - 1); end
        default:     adv_state = state_q;
      endcase
    end
    case (adv_state)
      ST_SOF:  adv_bit = 1'b0;
      ST_ID_A: adv_bit = id_a[adv_cnt[3:0]];
      ST_IDE:  adv_bit = ide_q;
      ST_ID_B: adv_bit = idf_q[adv_cnt[4:0]];
      ST_RTR:  adv_bit = rtr_q;
      ST_R1:   adv_bit = 1'b0;
      ST_R0:   adv_bit = 1'b0;
      ST_DLC:  adv_bit = dlc_q[adv_cnt[1:0]];
      ST_DATA: adv_bit = (state_q == ST_DATA) ? data_q[62] : data_q[63];
      ST_CRC:  adv_bit = crc_val[adv_cnt[3:0]];
      default: adv_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    tx_d      = tx_q;
    stf_d     = stf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    arb_d     = 1'b0;
    bit_err_d = 1'b0;
    ack_err_d = 1'b0;
    ide_d     = ide_q;
    rtr_d     = rtr_q;
    idf_d     = idf_q;
    dlc_d     = dlc_q;
    data_d    = data_q;
    no_data_d = no_data_q;
    dlast_d   = dlast_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = 1'b0;
    finish    = 1'b0;

    if (!busy_q) begin
      if (START) begin
        busy_d    = 1'b1;
        ide_d     = IDE;
        rtr_d     = RTR;
        idf_d     = IDF;
        dlc_d     = DLC;
        data_d    = DATA;
        no_data_d = RTR || (nb_clamped == 4'd0);
        dlast_d   = {nb_clamped[2:0] - 3'd1, 3'b111};
        crc_clr   = 1'b1;
      end
    end else begin
      // Sample-point check uses the level already on TX, so it wins over a coincident BIT_EN.
      if (SP && (state_q != ST_IDLE)) begin
        if (is_arb_field(state_q)) begin
          if (tx_q && !RX) begin
            arb_d  = 1'b1;
            finish = 1'b1;
          end else if (!tx_q && RX) begin
            bit_err_d = 1'b1;
            finish    = 1'b1;
          end
        end else if (state_q == ST_ACK_SLOT) begin
          if (RX) begin
            ack_err_d = 1'b1;
            finish    = 1'b1;
          end
        end else if (state_q == ST_IFS) begin
          if (!RX) begin
            finish = 1'b1;
          end else if (cnt_q == 6'd0) begin
            done_d = 1'b1;
            finish = 1'b1;
          end
        end else if (RX != tx_q) begin
          bit_err_d = 1'b1;
          finish    = 1'b1;
        end
      end

      if (finish) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
        stf_d   = 1'b0;
        cnt_d   = 6'd0;
        run_d   = 3'd0;
      end else if (BIT_EN) begin
        if (state_q == ST_IDLE) begin
          state_d = ST_SOF;
          cnt_d   = 6'd0;
          tx_d    = 1'b0;
          stf_d   = 1'b0;
          run_d   = 3'd1;
          crc_en  = 1'b1;
          crc_bit = 1'b0;
        end else if (is_stuffed(state_q) && (run_q == 3'(STUFF_RUN))) begin
          // Stuff bit: field position stays on the last real bit.
          tx_d  = ~tx_q;
          stf_d = 1'b1;
          run_d = 3'd1;
        end else begin
          state_d = adv_state;
          cnt_d   = adv_cnt;
          tx_d    = adv_bit;
          stf_d   = 1'b0;
          if ((adv_state == ST_DATA) && (state_q == ST_DATA)) begin
            data_d = {data_q[62:0], 1'b0};
          end
          if (in_crc_span(adv_state)) begin
            crc_en  = 1'b1;
            crc_bit = adv_bit;
          end
          if (is_stuffed(adv_state)) begin
            run_d = (adv_bit == tx_q) ? run_q + 3'd1 : 3'd1;
          end else begin
            run_d = 3'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      run_q     <= '0;
      tx_q      <= 1'b1;
      stf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arb_q     <= 1'b0;
      bit_err_q <= 1'b0;
      ack_err_q <= 1'b0;
      ide_q     <= 1'b0;
      rtr_q     <= 1'b0;
      idf_q     <= '0;
      dlc_q     <= '0;
      data_q    <= '0;
      no_data_q <= 1'b0;
      dlast_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      tx_q      <= tx_d;
      stf_q     <= stf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      arb_q     <= arb_d;
      bit_err_q <= bit_err_d;
      ack_err_q <= ack_err_d;
      ide_q     <= ide_d;
      rtr_q     <= rtr_d;
      idf_q     <= idf_d;
      dlc_q     <= dlc_d;
      data_q    <= data_d;
      no_data_q <= no_data_d;
      dlast_q   <= dlast_d;
    end
  end

  assign TX       = tx_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ARB_LOST = arb_q;
  assign BIT_ERR  = bit_err_q;
  assign ACK_ERR  = ack_err_q;
  assign STF_BIT  = stf_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: table of frames against a bit-level golden model,
// plus hand-written reset and abort sequences.
module tb_can_frame_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        BIT_EN, SP, RX, START, IDE, RTR;
  logic [28:0] IDF;
  logic [3:0]  DLC;
  logic [63:0] DATA;
  logic        TX, BUSY, DONE, ARB_LOST, BIT_ERR, ACK_ERR, STF_BIT;

  always #5 clk = ~clk;

  can_frame_tx #(.MAX_BYTES(8)) dut (
    .clk(clk), .reset_n(reset_n), .BIT_EN(BIT_EN), .SP(SP), .RX(RX), .START(START),
    .IDE(IDE), .RTR(RTR), .IDF(IDF), .DLC(DLC), .DATA(DATA),
    .TX(TX), .BUSY(BUSY), .DONE(DONE), .ARB_LOST(ARB_LOST), .BIT_ERR(BIT_ERR),
    .ACK_ERR(ACK_ERR), .STF_BIT(STF_BIT)
  );

  localparam int EV_NONE = -1;
  localparam int EV_DONE = 0;
  localparam int EV_ARB  = 1;
  localparam int EV_BIT  = 2;
  localparam int EV_ACK  = 3;

  typedef struct {
    logic        ide;
    logic        rtr;
    logic [28:0] idf;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          force_pos;   // -1 none, -2 the ACK slot
    logic        force_rx;
    int          restart_at;  // bit index for an extra START while busy, -1 none
    int          exp_evt;
    int          exp_end;     // bit index of the ending event, -1 derive from model
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  // Expected {STF_BIT, TX} per bit time, SOF through the last IFS bit.
  logic [1:0] exp_q[$];
  int         ack_pos;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic build_exp(input logic ide, input logic rtr, input logic [28:0] idf,
                           input logic [3:0] dlc, input logic [63:0] data);
    logic        d[$];
    logic [14:0] crc;
    logic        fb;
    logic        prev;
    int          n;
    int          run;
    exp_q.delete();
    d.push_back(1'b0);
    for (int i = 10; i >= 0; i--) d.push_back(ide ? idf[18 + i] : idf[i]);
    if (ide) begin
      d.push_back(1'b1);
      d.push_back(1'b1);
      for (int i = 17; i >= 0; i--) d.push_back(idf[i]);
      d.push_back(rtr);
      d.push_back(1'b0);
      d.push_back(1'b0);
    end else begin
      d.push_back(rtr);
      d.push_back(1'b0);
      d.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) d.push_back(dlc[i]);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < 8 * n; i++) d.push_back(data[63 - i]);
    crc = '0;
    for (int i = 0; i < d.size(); i++) begin
      fb  = d[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) d.push_back(crc[i]);
    run  = 0;
    prev = 1'b1;
    for (int i = 0; i < d.size(); i++) begin
      if (run > 0 && d[i] == prev) run++;
      else run = 1;
      prev = d[i];
      exp_q.push_back({1'b0, d[i]});
      if (run == 5) begin
        exp_q.push_back({1'b1, ~d[i]});
        prev = ~d[i];
        run  = 1;
      end
    end
    ack_pos = exp_q.size() + 1;
    repeat (13) exp_q.push_back(2'b01);
  endtask

  task automatic bit_en_pulse(output logic [1:0] got);
    @(negedge clk) BIT_EN = 1'b1;
    @(negedge clk) BIT_EN = 1'b0;
    got = {STF_BIT, TX};
  endtask

  task automatic sp_pulse(input logic rx, output logic [3:0] pulses);
    @(negedge clk);
    RX = rx;
    SP = 1'b1;
    @(negedge clk) SP = 1'b0;
    pulses = {DONE, ARB_LOST, BIT_ERR, ACK_ERR};
  endtask

  function automatic int evt_of(input logic [3:0] p);
    case (p)
      4'b0000: return EV_NONE;
      4'b1000: return EV_DONE;
      4'b0100: return EV_ARB;
      4'b0010: return EV_BIT;
      4'b0001: return EV_ACK;
      default: return 9;
    endcase
  endfunction

  task automatic start_frame(input logic ide, input logic rtr, input logic [28:0] idf,
                             input logic [3:0] dlc, input logic [63:0] data);
    @(negedge clk);
    IDE = ide; RTR = rtr; IDF = idf; DLC = dlc; DATA = data;
    START = 1'b1;
    @(negedge clk) START = 1'b0;
    check("busy_after_start", BUSY, 1'b1);
  endtask

  task automatic run_vector(input int vi);
    vec_t       v;
    logic [1:0] got;
    logic [1:0] exp_bit;
    logic [3:0] pulses;
    logic       rx;
    int         fpos;
    int         end_idx;
    int         evt;
    int         want_end;
    v = vecs[vi];
    build_exp(v.ide, v.rtr, v.idf, v.dlc, v.data);
    start_frame(v.ide, v.rtr, v.idf, v.dlc, v.data);
    fpos     = (v.force_pos == -2) ? ack_pos : v.force_pos;
    want_end = v.exp_end;
    if (want_end < 0) want_end = (v.exp_evt == EV_ACK) ? ack_pos : exp_q.size() - 1;
    end_idx = -1;
    evt     = EV_NONE;
    for (int i = 0; i < 150; i++) begin
      exp_bit = (i < exp_q.size()) ? exp_q[i] : 2'b01;
      bit_en_pulse(got);
      check($sformatf("v%0d_bit%0d_stf_tx", vi, i), got, exp_bit);
      if (i == v.restart_at) begin
        IDF = ~v.idf; DLC = 4'd3; IDE = ~v.ide;
        START = 1'b1;
        @(negedge clk) START = 1'b0;
      end
      rx = exp_bit[0];
      if (i == ack_pos) rx = 1'b0;
      if (i == fpos) rx = v.force_rx;
      sp_pulse(rx, pulses);
      if (pulses != 4'b0000) begin
        evt     = evt_of(pulses);
        end_idx = i;
        break;
      end
    end
    RX = 1'b1;
    check($sformatf("v%0d_event", vi), evt, v.exp_evt);
    check($sformatf("v%0d_end_bit", vi), end_idx, want_end);
    check($sformatf("v%0d_busy_after", vi), BUSY, 1'b0);
    check($sformatf("v%0d_tx_after", vi), TX, 1'b1);
    if (v.exp_evt != EV_DONE) begin
      for (int k = 0; k < 3; k++) begin
        bit_en_pulse(got);
        check($sformatf("v%0d_post%0d_stf_tx", vi, k), got, 2'b01);
        sp_pulse(1'b1, pulses);
        check($sformatf("v%0d_post%0d_pulses", vi, k), pulses, 4'b0000);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx"},    TX, 1'b1);
    check({tag, "_busy"},  BUSY, 1'b0);
    check({tag, "_done"},  DONE, 1'b0);
    check({tag, "_arb"},   ARB_LOST, 1'b0);
    check({tag, "_biterr"}, BIT_ERR, 1'b0);
    check({tag, "_ackerr"}, ACK_ERR, 1'b0);
    check({tag, "_stf"},   STF_BIT, 1'b0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [1:0] got;
    logic [3:0] pulses;

    vecs[0] = '{1'b0, 1'b0, 29'h0,        4'd0,  64'h0,                  -1, 1'b0, -1, EV_DONE, 52};
    vecs[1] = '{1'b0, 1'b0, 29'h123,      4'd2,  64'hA55A_1234_5678_9ABC, -1, 1'b0,  5, EV_DONE, -1};
    vecs[2] = '{1'b1, 1'b1, 29'h1FFFFFFF, 4'd8,  64'hDEAD_BEEF_0BAD_F00D, -1, 1'b0, -1, EV_DONE, -1};
    vecs[3] = '{1'b0, 1'b0, 29'h400,      4'd1,  64'h8000_0000_0000_0000,  1, 1'b0, -1, EV_ARB,   1};
    vecs[4] = '{1'b0, 1'b0, 29'h555,      4'd1,  64'hFF00_0000_0000_0000, -2, 1'b1, -1, EV_ACK,  -1};
    vecs[5] = '{1'b0, 1'b0, 29'h555,      4'd1,  64'hFF00_0000_0000_0000, 20, 1'b0, -1, EV_BIT,  20};
    vecs[6] = '{1'b0, 1'b0, 29'h7FF,      4'd15, 64'h0123_4567_89AB_CDEF, -1, 1'b0, -1, EV_DONE, -1};

    reset_n = 1'b0;
    BIT_EN = 1'b0; SP = 1'b0; RX = 1'b1; START = 1'b0;
    IDE = 1'b0; RTR = 1'b0; IDF = '0; DLC = '0; DATA = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    for (int vi = 0; vi < 7; vi++) run_vector(vi);

    // Asynchronous reset while a dominant DATA bit is on the bus.
    build_exp(1'b0, 1'b0, 29'h123, 4'd2, 64'hA55A_1234_5678_9ABC);
    start_frame(1'b0, 1'b0, 29'h123, 4'd2, 64'hA55A_1234_5678_9ABC);
    for (int i = 0; i < 21; i++) begin
      bit_en_pulse(got);
      check($sformatf("rst_bit%0d_stf_tx", i), got, exp_q[i]);
      sp_pulse(exp_q[i][0], pulses);
      check($sformatf("rst_bit%0d_pulses", i), pulses, 4'b0000);
    end
    bit_en_pulse(got);
    check("rst_data_bit_dominant", got, 2'b00);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk) reset_n = 1'b1;
    bit_en_pulse(got);
    check("rst_release_stf_tx", got, 2'b01);
    check_idle_outputs("rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_frame_tx.md
Name: can_frame_tx

Overview:
- Classic CAN 2.0A/2.0B frame transmitter. It is the transmit-side counterpart of the frame receiver.
- Serializes one base or extended data/remote frame onto TX, MSB first, with bit stuffing and CRC-15 generation.
- Monitors RX at the sample point for arbitration loss, bit error and missing ACK.
- Error/overload frame generation belongs to a separate block, driven by the error pulses from this block.

Parameters:
- MAX_BYTES, 8, maximum data-field length; DLC values 9..15 are clamped to this.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- BIT_EN  in  1  one-clk strobe per bit time, at bit start; TX advances here
- SP  in  1  one-clk strobe at the sample point; RX is compared here
- RX  in  1  bus level (0 = dominant)
- START  in  1  one-clk request; frame fields are captured when BUSY=0
- IDE  in  1  1 = extended frame
- RTR  in  1  1 = remote frame
- IDF  in  29  identifier; base frames use IDF[10:0]; extended frames use IDF[28:18] then IDF[17:0]
- DLC  in  4  data length code
- DATA  in  64  byte0 = DATA[63:56]; transmitted MSB first
- TX  out  1  bus drive (1 = recessive)
- BUSY  out  1  frame in progress
- DONE  out  1  one-clk pulse after IFS completes
- ARB_LOST  out  1  one-clk pulse
- BIT_ERR  out  1  one-clk pulse
- ACK_ERR  out  1  one-clk pulse
- STF_BIT  out  1  high while TX carries a stuff bit

Behaviour:
- Reset: TX=1, BUSY=0, DONE=ARB_LOST=BIT_ERR=ACK_ERR=STF_BIT=0, state IDLE, counters=0, CRC=0.
- Reset asserted mid-frame: TX goes recessive immediately (asynchronous); no pulses are generated.
- START with BUSY=1 is ignored. START with BUSY=0: fields are latched, BUSY=1 on the next clk, and SOF is driven at the next BIT_EN.
- TX is registered and updates only in a clk cycle with BIT_EN=1.
- States and field lengths, in order:
  - IDLE
  - SOF 1
  - ID_A 11
  - Base: RTR 1, IDE 1 (=0), R0 1
  - Extended: SRR 1 (=1), IDE 1 (=1), ID_B 18, RTR 1, R1 1, R0 1 (reserved bits=0)
  - DLC 4
  - DATA 8*min(DLC,MAX_BYTES); skipped when RTR=1 or DLC=0
  - CRC 15, CRC_DEL 1, ACK_SLOT 1, ACK_DEL 1, EOF 7, IFS 3
  - IFS ends → IDLE with DONE pulse.
- Field bit counter: 0-based; loaded with length-1 on entry, decremented per non-stuff bit; the state transitions when it reaches 0.
- DLC field transmits the raw DLC value; only the data length is clamped.
- CRC-15 (poly 0x4599, init 0):
  - Covers destuffed bits SOF..last data bit.
  - Stuff bits are excluded.
  - Shifted out MSB first in CRC state.
- Bit stuffing:
  - Active from SOF through the last CRC bit.
  - After 5 consecutive equal TX bits (stuff bits count toward runs), the next BIT_EN drives the complement, STF_BIT=1, and the field counter does not advance.
  - A stuff bit owed after the last CRC bit is still sent, before CRC_DEL.
  - The run counter resets on entering CRC_DEL.
- Monitoring at SP, against the currently driven TX:
  - If SP and BIT_EN coincide, compare first, then update.
  - Arbitration field (ID_A, SRR, IDE, ID_B, RTR, including stuff bits there): TX=1 and RX=0 → ARB_LOST pulse, TX=1, go to IDLE, BUSY=0. No DONE.
  - ACK_SLOT: TX=1; RX=1 → ACK_ERR pulse, go to IDLE; RX=0 → continue.
  - Any other state except IDLE and IFS: RX≠TX → BIT_ERR pulse, TX=1, go to IDLE.
  - IFS: RX=0 → go to IDLE with no DONE; overload handling belongs to the downstream block.
- Error pulses and DONE are mutually exclusive. At most one error pulse per frame.
- After abort, a new START is accepted in the next cycle.

Decomposition:
- Package can_pkg:
  - Transmitter state enum
  - CRC15_POLY
  - Field-length constants: ID_A_LEN=11, ID_B_LEN=18, DLC_LEN=4, CRC_LEN=15, EOF_LEN=7, IFS_LEN=3
  - STUFF_RUN=5
- Sub-module can_crc15: serial CRC register with clear, shift-enable and data-bit input. The receiver reuses the same sub-module.

Test Plan:
- Base, IDF=0, RTR=0, DLC=0, RX mirrors TX, except RX=0 at ACK_SLOT:
  - 34 dominant payload bits (19 header + 15 CRC) plus 6 stuff bits.
  - Stuff bits after payload zeros #5,10,15,20,25,30.
  - 40 bit times SOF..CRC, then 1,1(ACK driven),1 and 7 ones of EOF.
  - DONE after 3 IFS bits; 53 BIT_EN total.
- Base, IDF=0x123, DLC=2, DATA=0xA55A…:
  - TX bitstream and CRC match the golden model.
  - STF_BIT aligned with every inserted bit.
- Extended, IDF=0x1FFFFFFF, RTR=1, DLC=8:
  - No DATA state.
  - SRR=1 and IDE=1 driven.
  - DLC field=1000.
  - CRC matches the golden model.
- Arbitration loss: force RX=0 at SP of the first recessive ID bit of IDF=0x400:
  - ARB_LOST pulse.
  - TX=1 from the next BIT_EN onward.
  - BUSY=0, no DONE.
- ACK missing: RX=1 at ACK_SLOT → ACK_ERR pulse, no DONE.
- Error and control corner cases:
  - Bit error: RX=0 at SP while TX=1 in DATA → BIT_ERR pulse.
  - START while BUSY is ignored.
  - reset_n low mid-DATA → TX=1 asynchronously; all outputs at reset values.
